// File: rtl/osd_trace_arbiter.sv
// Round-robin arbiter sharing one trace packetizer between N trace sources.
// Each grant forwards one whole record: either a pending drop-count overflow
// record or the source's next data record. Overflow records always go out
// ahead of that source's next data record.
module osd_trace_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N*WIDTH-1:0]              in_data,
    input  logic [N-1:0]                    in_valid,
    output logic [N-1:0]                    in_ready,
    input  logic [N-1:0]                    in_drop,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_overflow,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_sel
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q [N];
    logic [CNT_W-1:0]   cnt_d [N];

    logic [N-1:0]       req;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               ovf_ack;

    // A source requests when it has a record or unreported drops.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i] = in_valid[i] | (cnt_q[i] != '0);
        end
    end

    // Round-robin pick: first requester after the last served source, with wrap.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(idx);
            end
        end
    end

    // Grant FSM next state and packetizer-side outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        ovf_pend_d   = ovf_pend_q;
        snap_d       = snap_q;
        out_valid    = 1'b0;
        out_overflow = 1'b0;
        out_data     = '0;
        in_ready     = '0;
        ovf_ack      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    ovf_pend_d = (cnt_q[pick_idx] != '0);
                    snap_d     = cnt_q[pick_idx];
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                out_valid = 1'b1;
                if (ovf_pend_q) begin
                    // Overflow record: snapshot count, source record untouched.
                    out_overflow = 1'b1;
                    out_data     = {{(WIDTH-CNT_W){1'b0}}, snap_q};
                    if (out_ready) begin
                        ovf_ack = 1'b1;
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end else begin
                    out_data          = in_data[int'(grant_q)*WIDTH +: WIDTH];
                    in_ready[grant_q] = out_ready;
                    if (out_ready) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_sel = grant_q;

    // Drop counters: saturating increment, minus the reported snapshot on overflow handshake.
    always_comb begin
        logic [CNT_W:0] sum;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (ovf_ack && (grant_q == SEL_W'(i))) begin
                // Drops seen since the snapshot stay counted.
                sum = {1'b0, cnt_q[i]} - {1'b0, snap_q} + (CNT_W+1)'(in_drop[i]);
            end else begin
                sum = {1'b0, cnt_q[i]} + (CNT_W+1)'(in_drop[i]);
            end
            cnt_d[i] = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= SEL_W'(N - 1);
            ovf_pend_q <= 1'b0;
            snap_q     <= '0;
            // NOTE: the counter array is architectural state, so unlike a data RAM it is reset element by element.
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            ovf_pend_q <= ovf_pend_d;
            snap_q     <= snap_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_osd_trace_arbiter.sv
// Scoreboard bench for osd_trace_arbiter: stimulus pushes expected records,
// a monitor pops and compares on every out_valid/out_ready handshake.
module tb_osd_trace_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [1:0]  sel;
        logic        ovf;
        logic [31:0] data;
    } rec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N-1:0]       in_drop;
    logic [WIDTH-1:0]   out_data;
    logic               out_overflow;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_sel;

    rec_t               exp_q [$];
    logic [WIDTH-1:0]   src_q [N][$];
    logic [N-1:0]       hs_vec = '0;
    int                 hs_cyc_q [$];
    int                 cyc = 0;
    int                 total = 0;
    int                 bad = 0;

    osd_trace_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_drop      (in_drop),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [1:0] sel, input logic ovf, input logic [31:0] data);
        rec_t e;
        e.sel  = sel;
        e.ovf  = ovf;
        e.data = data;
        exp_q.push_back(e);
    endtask

    function automatic int pending();
        int n;
        n = exp_q.size();
        for (int i = 0; i < N; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && pending() != 0; k++) tick();
        check({name, "_drained"}, pending(), 0);
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        check({name, "_valid"}, out_valid, 1);
    endtask

    // Monitor: compares every handshake against the scoreboard head.
    initial begin
        rec_t        e;
        logic [3:0]  exp_rdy;
        forever begin
            @(negedge clk);
            cyc++;
            hs_vec = rst_n ? (in_valid & in_ready) : '0;
            if (rst_n && out_valid && !out_overflow)
                assert (in_valid[out_sel]) else $error("protocol: granted source withdrew in_valid");
            if (rst_n && out_valid && out_ready) begin
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_record: got sel=%0d ovf=%0d data=%h, none expected",
                             out_sel, out_overflow, out_data);
                end else begin
                    e = exp_q.pop_front();
                    exp_rdy = e.ovf ? 4'b0000 : (4'b0001 << e.sel);
                    check("record", {25'd0, out_sel, out_overflow, out_data, in_ready},
                          {25'd0, e.sel, e.ovf, e.data, exp_rdy});
                end
            end
        end
    end

    // Source feeders: present queue heads, retire them after a consumed handshake.
    initial begin
        in_valid = '0;
        in_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_vec[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                hs_vec[i] = 1'b0;
                in_valid[i] = (src_q[i].size() != 0);
                in_data[i*WIDTH +: WIDTH] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH+2:0] ref_hold;
        bit               found;
        in_drop   = '0;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #2;
        check("reset_outputs", {out_valid, out_overflow, out_sel, out_data, in_ready}, 64'd0);

        // Sources 0 and 2 valid from reset: grants alternate 0,2,0,2.
        src_q[0].push_back(32'h0000_00A0);
        src_q[0].push_back(32'h0000_00A1);
        src_q[2].push_back(32'h0000_00C0);
        src_q[2].push_back(32'h0000_00C1);
        push_exp(2'd0, 1'b0, 32'h0000_00A0);
        push_exp(2'd2, 1'b0, 32'h0000_00C0);
        push_exp(2'd0, 1'b0, 32'h0000_00A1);
        push_exp(2'd2, 1'b0, 32'h0000_00C1);
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_drain("t1", 60);
        check("t1_handshakes", hs_cyc_q.size(), 4);
        if (hs_cyc_q.size() >= 4)
            check("t1_spacing", hs_cyc_q[3] - hs_cyc_q[0], 6);

        // Three drops on source 1 while source 0 holds the grant, then a data record.
        out_ready = 1'b0;
        src_q[0].push_back(32'h0000_00B0);
        push_exp(2'd0, 1'b0, 32'h0000_00B0);
        wait_valid("t2");
        in_drop = 4'b0010;
        repeat (3) tick();
        in_drop = '0;
        src_q[1].push_back(32'hDEAD_BEEF);
        push_exp(2'd1, 1'b1, 32'd3);
        push_exp(2'd1, 1'b0, 32'hDEAD_BEEF);
        tick();
        out_ready = 1'b1;
        wait_drain("t2", 60);

        // 1100 drops on source 3 saturate its counter at 1023.
        out_ready = 1'b0;
        src_q[0].push_back(32'h0000_00B1);
        push_exp(2'd0, 1'b0, 32'h0000_00B1);
        push_exp(2'd3, 1'b1, 32'd1023);
        wait_valid("t3");
        in_drop = 4'b1000;
        repeat (1100) tick();
        in_drop = '0;
        out_ready = 1'b1;
        wait_drain("t3", 60);

        // Drop arriving in the overflow handshake cycle survives the clear.
        out_ready = 1'b0;
        src_q[0].push_back(32'h0000_00B2);
        push_exp(2'd0, 1'b0, 32'h0000_00B2);
        push_exp(2'd1, 1'b1, 32'd5);
        push_exp(2'd1, 1'b1, 32'd1);
        wait_valid("t4");
        in_drop = 4'b0010;
        repeat (5) tick();
        in_drop = '0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_overflow && out_sel == 2'd1) found = 1'b1;
        end
        in_drop = found ? 4'b0010 : 4'b0000;
        tick();
        in_drop = '0;
        check("t4_ovf_seen", found, 1);
        wait_drain("t4", 60);

        // Back-pressure: outputs hold for 10 cycles, in_ready stays low.
        out_ready = 1'b0;
        src_q[2].push_back(32'h1234_5678);
        push_exp(2'd2, 1'b0, 32'h1234_5678);
        wait_valid("t5");
        @(negedge clk);
        ref_hold = {out_valid, out_sel, out_data};
        check("t5_first_view", {29'd0, ref_hold}, {29'd0, 1'b1, 2'd2, 32'h1234_5678});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_hold", {25'd0, out_valid, out_sel, out_data, in_ready}, {25'd0, ref_hold, 4'b0000});
        end
        tick();
        out_ready = 1'b1;
        wait_drain("t5", 60);

        // Reset while busy with cnt[0]=7: record abandoned, counts lost.
        out_ready = 1'b0;
        src_q[1].push_back(32'h1111_1111);
        wait_valid("t6");
        check("t6_grant_sel", out_sel, 1);
        src_q[0].push_back(32'h0000_0A0A);
        in_drop = 4'b0001;
        repeat (7) tick();
        in_drop = '0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {out_valid, out_overflow, out_sel, out_data, in_ready}, 64'd0);
        push_exp(2'd0, 1'b0, 32'h0000_0A0A);
        push_exp(2'd1, 1'b0, 32'h1111_1111);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_drain("t6", 60);

        repeat (3) tick();
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
